sm_sub_arbiter: RTL and testbench

- Shares one combinational 16-bit sign-magnitude subtractor datapath among NREQ requesters.
- Number format: bit W-1 is the sign; bits W-2:0 are the magnitude.
- Arbitrates round-robin, registers the winner's operands onto the shared datapath, holds them stable for LAT cycles, then captures the result and returns it with a one-cycle done pulse.
- Sits between the client blocks and the single subtractor instance. The subtractor stays purely combinational and has no knowledge of the arbiter.

---
 rtl/sm_sub_arbiter_if.sv | 50 +++++
 rtl/sm_sub_arbiter.sv | 159 +++++++++++++++
 tb/tb_sm_sub_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_sub_arbiter_if.sv
// Bundle of the requester-side and subtractor-side signals around the
// shared sign-magnitude subtractor arbiter.
interface sm_sub_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
);

  // Requester side
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      res_out;
  logic              busy;

  // Shared subtractor side
  logic [W-1:0]      sub_a;
  logic [W-1:0]      sub_b;
  logic [W-1:0]      sub_res;

  // Arbiter view
  modport slave (
    input  req,
    input  a_in,
    input  b_in,
    input  sub_res,
    output gnt,
    output done,
    output res_out,
    output busy,
    output sub_a,
    output sub_b
  );

  // Environment view: clients plus the combinational subtractor
  modport master (
    output req,
    output a_in,
    output b_in,
    output sub_res,
    input  gnt,
    input  done,
    input  res_out,
    input  busy,
    input  sub_a,
    input  sub_b
  );

endinterface

// File: rtl/sm_sub_arbiter.sv
// Round-robin arbiter that time-shares one combinational sign-magnitude
// subtractor among NREQ requesters. Operands are registered onto the shared
// datapath, held for LAT cycles of settling, then the result is captured.
module sm_sub_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16,
  parameter int unsigned LAT  = 2
) (
  input logic             clk,
  input logic             rst_n,
  sm_sub_arbiter_if.slave bus_io
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [CntW-1:0] CntInit = CntW'(LAT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NREQ - 1);
  localparam logic [IdxW:0]   NreqW   = (IdxW + 1)'(NREQ);

  if (LAT < 1) begin : gen_bad_lat
    $error("sm_sub_arbiter: LAT must be at least 1");
  end
  if (NREQ < 2 || NREQ > 8) begin : gen_bad_nreq
    $error("sm_sub_arbiter: NREQ must be in 2..8");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    sub_a_q, sub_a_d;
  logic [W-1:0]    sub_b_q, sub_b_d;

  // Round-robin search result
  logic            found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW:0]   cand_sum;

  // Pick the first requester at or above ptr, wrapping past NREQ-1 to 0
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (IdxW + 1)'(i);
      if (cand_sum >= NreqW) begin
        cand_sum = cand_sum - NreqW;
      end
      if (!found && bus_io.req[cand_sum[IdxW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand_sum[IdxW-1:0];
      end
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE operation cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    res_d   = res_q;
    sub_a_d = sub_a_q;
    sub_b_d = sub_b_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          sub_a_d = bus_io.a_in[win_idx*W +: W];
          sub_b_d = bus_io.b_in[win_idx*W +: W];
          gnt_d   = '0;
          gnt_d[win_idx] = 1'b1;
          win_d   = win_idx;
          cnt_d   = CntInit;
          state_d = StRun;
        end
      end

      StRun: begin
        // Operands stay frozen here; only the settle counter moves
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_d   = bus_io.sub_res;
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = (win_q == IdxLast) ? '0 : win_q + 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        // Dead cycle: no arbitration while done is pulsing
        done_d  = '0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        done_d  = '0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      sub_a_q <= '0;
      sub_b_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      sub_a_q <= sub_a_d;
      sub_b_q <= sub_b_d;
    end
  end

  // Output drive; everything except busy comes straight from a register
  always_comb begin
    bus_io.gnt     = gnt_q;
    bus_io.done    = done_q;
    bus_io.res_out = res_q;
    bus_io.busy    = (state_q != StIdle);
    bus_io.sub_a   = sub_a_q;
    bus_io.sub_b   = sub_b_q;
  end

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_done_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_q));
  a_done_not_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(|(done_q & gnt_q)));
`endif

endmodule

// File: tb/tb_sm_sub_arbiter.sv
// Directed bench for sm_sub_arbiter with a behavioural sign-magnitude
// subtractor attached and a scoreboard of expected done/result pairs.
module tb_sm_sub_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned LAT  = 2;

  typedef struct packed {
    logic [NREQ-1:0] done;
    logic [W-1:0]    res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic force_en = 1'b0;
  logic [W-1:0] force_val = '0;

  int n_checks = 0;
  int n_errs = 0;
  int cyc = 0;
  int last_gnt_cyc = 0;
  exp_t sb[$];

  sm_sub_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  sm_sub_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Reference sign-magnitude subtractor standing in for the shared datapath
  function automatic logic [W-1:0] sm_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic          sa, sbn;
    logic [W-2:0]  ma, mb;
    sa  = a[W-1];
    sbn = ~b[W-1];
    ma  = a[W-2:0];
    mb  = b[W-2:0];
    if (sa == sbn) return {sa, ma + mb};
    else if (ma >= mb) return {sa, ma - mb};
    else return {sbn, mb - ma};
  endfunction

  assign bus.sub_res = force_en ? force_val : sm_sub(bus.sub_a, bus.sub_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] d, input logic [W-1:0] r);
    exp_t e;
    e.done = d;
    e.res  = r;
    sb.push_back(e);
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[idx*W +: W] = a;
    bus.b_in[idx*W +: W] = b;
  endtask

  // Advance to the next falling edge and retire any done pulse
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.done !== '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("done_vec", 32'(bus.done), 32'(e.done));
        chk("res_out", 32'(bus.res_out), 32'(e.res));
        chk("done_gnt_overlap", 32'(bus.done & bus.gnt), 32'h0);
      end
    end
  endtask

  // Wait for a grant, check it, wait for its done, then drop the given reqs
  task automatic serve(input int idx, input logic [NREQ-1:0] clr, input bit gap_chk);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.gnt == '0 && n < 20);
    chk($sformatf("gnt_req%0d", idx), 32'(bus.gnt), 32'(1) << idx);
    if (gap_chk) chk("grant_gap", cyc - last_gnt_cyc, LAT + 2);
    last_gnt_cyc = cyc;
    n = 0;
    while (bus.done == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("done_wait", 32'(n < 20), 32'h1);
    bus.req = bus.req & ~clr;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;

    // Asynchronous reset takes effect before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_sub_a", 32'(bus.sub_a), 32'h0);
    chk("rst_sub_b", 32'(bus.sub_b), 32'h0);
    chk("rst_res", 32'(bus.res_out), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request, detailed cycle timing
    set_ops(2, 16'h0005, 16'h0003);
    push(4'b0100, 16'h0002);
    bus.req = 4'b0100;
    tick();
    chk("t1_gnt", 32'(bus.gnt), 32'h4);
    chk("t1_sub_a", 32'(bus.sub_a), 32'h0005);
    chk("t1_sub_b", 32'(bus.sub_b), 32'h0003);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("t1_gnt_hold", 32'(bus.gnt), 32'h4);
    chk("t1_no_early_done", 32'(bus.done), 32'h0);
    tick();
    chk("t1_done", 32'(bus.done), 32'h4);
    chk("t1_gnt_clear", 32'(bus.gnt), 32'h0);
    chk("t1_busy_done", 32'(bus.busy), 32'h1);
    bus.req = '0;
    tick();
    chk("t1_busy_low", 32'(bus.busy), 32'h0);
    chk("t1_done_low", 32'(bus.done), 32'h0);
    tick();
    chk("t1_idle_gnt", 32'(bus.gnt), 32'h0);

    // Negative results; ptr=3 so requester 0 wins first
    set_ops(0, 16'h0003, 16'h0005);
    set_ops(1, 16'h8004, 16'h0001);
    push(4'b0001, 16'h8002);
    push(4'b0010, 16'h8005);
    bus.req = 4'b0011;
    serve(0, 4'b0001, 1'b0);
    serve(1, 4'b0010, 1'b0);

    // Negative zero from the datapath passes through untouched
    set_ops(3, 16'h1234, 16'h0001);
    force_val = 16'h8000;
    force_en  = 1'b1;
    push(4'b1000, 16'h8000);
    bus.req = 4'b1000;
    serve(3, 4'b1000, 1'b0);
    force_en = 1'b0;

    // Fresh reset, then all requesters held high
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ops(0, 16'h000A, 16'h0003);
    set_ops(1, 16'h0001, 16'h0009);
    set_ops(2, 16'h8003, 16'h0004);
    set_ops(3, 16'h0100, 16'h8100);
    push(4'b0001, 16'h0007);
    push(4'b0010, 16'h8008);
    push(4'b0100, 16'h8007);
    push(4'b1000, 16'h0200);
    push(4'b0001, 16'h0007);
    push(4'b0010, 16'h8008);
    bus.req = 4'b1111;
    serve(0, 4'b0000, 1'b0);
    serve(1, 4'b0000, 1'b1);
    serve(2, 4'b0000, 1'b1);
    serve(3, 4'b0000, 1'b1);
    serve(0, 4'b0000, 1'b1);
    serve(1, 4'b1111, 1'b1);

    // ptr=2: requesters 3 then 1; then ptr=2 again: 2 then 0
    push(4'b1000, 16'h0200);
    push(4'b0010, 16'h8008);
    bus.req = 4'b1010;
    serve(3, 4'b1000, 1'b0);
    serve(1, 4'b0010, 1'b0);
    push(4'b0100, 16'h8007);
    push(4'b0001, 16'h0007);
    bus.req = 4'b0101;
    serve(2, 4'b0100, 1'b0);
    serve(0, 4'b0001, 1'b0);

    // Operands are frozen once granted
    set_ops(0, 16'h0007, 16'h0001);
    push(4'b0001, 16'h0006);
    bus.req = 4'b0001;
    tick();
    chk("frz_dead_cycle", 32'(bus.gnt), 32'h0);
    tick();
    chk("frz_gnt", 32'(bus.gnt), 32'h1);
    chk("frz_sub_a0", 32'(bus.sub_a), 32'h0007);
    set_ops(0, 16'h7FFF, 16'h0001);
    tick();
    chk("frz_sub_a1", 32'(bus.sub_a), 32'h0007);
    tick();
    chk("frz_res", 32'(bus.res_out), 32'h0006);
    bus.req = '0;
    tick();

    // Reset in the middle of RUN; ptr was 1 beforehand
    set_ops(0, 16'h0020, 16'h0010);
    set_ops(1, 16'h0009, 16'h0002);
    bus.req = 4'b0011;
    tick();
    chk("mr_gnt_pre", 32'(bus.gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mr_gnt", 32'(bus.gnt), 32'h0);
    chk("mr_busy", 32'(bus.busy), 32'h0);
    chk("mr_res", 32'(bus.res_out), 32'h0);
    chk("mr_done", 32'(bus.done), 32'h0);
    chk("mr_sub_a", 32'(bus.sub_a), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    push(4'b0001, 16'h0010);
    push(4'b0010, 16'h0007);
    serve(0, 4'b0001, 1'b0);
    serve(1, 4'b0010, 1'b0);
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("final_busy", 32'(bus.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
